// File: rtl/aes_block_loader.sv
// Feeds the AES core: packs 4x32b words into a block, holds en until the core answers,
// and hands the ciphertext downstream. Define AES_LOADER_CBC_EN for CBC chaining (iv_in/iv_load).
module aes_block_loader #(
  parameter int TIMEOUT_CYC = 255,
  parameter int MIN_GAP     = 2
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [127:0] key_in,
  output logic         core_en,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic         core_valid,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_LOADER_CBC_EN
  input  logic [127:0] iv_in,
  input  logic         iv_load,
`endif
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr
);
  typedef enum logic [2:0] {FILL, ISSUE, WAIT, OUT, GAP} state_t;

  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYC);
  localparam logic [3:0]  GAP_LAST = 4'(MIN_GAP - 1);

  state_t       state;
  logic [1:0]   wcnt;
  logic [127:0] blk, blk_nxt, issue_data;
  logic [15:0]  tcnt;
  logic [3:0]   gcnt;

  // first word of a block lands in the top lane
  always_comb begin
    blk_nxt = blk;
    unique case (wcnt)
      2'd0: blk_nxt[127:96] = in_data;
      2'd1: blk_nxt[95:64]  = in_data;
      2'd2: blk_nxt[63:32]  = in_data;
      default: blk_nxt[31:0] = in_data;
    endcase
  end

`ifdef AES_LOADER_CBC_EN
  logic [127:0] chain;
  assign issue_data = blk_nxt ^ chain;

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n)                     chain <= '0;
    else if (state == FILL && iv_load)  chain <= iv_in;
    else if (state == WAIT && core_valid) chain <= core_result;
  end
`else
  assign issue_data = blk_nxt;
`endif

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state       <= FILL;
      wcnt        <= '0;
      blk         <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
      in_ready    <= 1'b1;
      core_en     <= 1'b0;
      core_data   <= '0;
      core_key    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // a timeout set below overrides this clear
      if (err_clr) timeout_err <= 1'b0;
      unique case (state)
        FILL: if (in_valid) begin
          blk  <= blk_nxt;
          wcnt <= wcnt + 2'd1;
          if (wcnt == 2'd3) begin
            core_data <= issue_data;
            core_key  <= key_in;
            core_en   <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core_valid) begin
            out_data  <= core_result;
            out_valid <= 1'b1;
            core_en   <= 1'b0;
            state     <= OUT;
          end else if (tcnt + 16'd1 == TO_LIM) begin
            core_en     <= 1'b0;
            timeout_err <= 1'b1;
            gcnt        <= '0;
            state       <= GAP;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          gcnt      <= '0;
          state     <= GAP;
        end
        GAP: begin
          if (gcnt == GAP_LAST) begin
            wcnt     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= FILL;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: two instances (default timeout, short timeout) driven by a
// behavioural core stub returning data^key N cycles after en rises.
module tb_aes_block_loader;
  localparam int GAP0 = 2, GAP1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid;
  logic [31:0]  in_data;
  logic [127:0] key_in;
  logic [1:0]   ivl, rdy, en, ovld, ordy, busy, terr, eclr;
  logic [1:0]   cval = '0;
  logic [127:0] cdata [2], ckey [2], odata [2];
  logic [127:0] cres [2] = '{default: '0};
`ifdef AES_LOADER_CBC_EN
  logic [127:0] iv_in;
  logic [1:0]   iv_load;
`endif

  int           sel;
  int           n_cmp = 0, n_bad = 0;
  int           stub_n [2];
  logic         never [2];
  logic         spur;
  int           en_age [2], en_len [2];
  logic [127:0] chain_m [2];

  typedef struct {
    logic [127:0] blk;
    logic [127:0] key;
    logic [127:0] exp_out;
    int           n;
  } vec_t;

  assign ivl = {in_valid && sel == 1, in_valid && sel == 0};

  aes_block_loader u_main (
    .AES_clk(clk), .AES_rst_n(rst_n), .in_valid(ivl[0]), .in_ready(rdy[0]),
    .in_data(in_data), .key_in(key_in), .core_en(en[0]), .core_data(cdata[0]),
    .core_key(ckey[0]), .core_valid(cval[0]), .core_result(cres[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_data(odata[0]),
`ifdef AES_LOADER_CBC_EN
    .iv_in(iv_in), .iv_load(iv_load[0]),
`endif
    .busy(busy[0]), .timeout_err(terr[0]), .err_clr(eclr[0]));

  aes_block_loader #(.TIMEOUT_CYC(8), .MIN_GAP(GAP1)) u_to (
    .AES_clk(clk), .AES_rst_n(rst_n), .in_valid(ivl[1]), .in_ready(rdy[1]),
    .in_data(in_data), .key_in(key_in), .core_en(en[1]), .core_data(cdata[1]),
    .core_key(ckey[1]), .core_valid(cval[1]), .core_result(cres[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_data(odata[1]),
`ifdef AES_LOADER_CBC_EN
    .iv_in(iv_in), .iv_load(iv_load[1]),
`endif
    .busy(busy[1]), .timeout_err(terr[1]), .err_clr(eclr[1]));

  // core stub: valid on the Nth cycle after en rises, junk/spurious pulses while en is low
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        cval[i] = !never[i] && en_age[i] == stub_n[i];
        cres[i] = cdata[i] ^ ckey[i];
        en_age[i]++;
      end else begin
        if (en_age[i] != 0) en_len[i] = en_age[i];
        en_age[i] = 0;
        cval[i] = spur && ($urandom_range(0, 1) == 1);
        cres[i] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic bad(input string name, input string msg);
    n_cmp++; n_bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %h want %h", name, act, exp); end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %b want %b", name, act, exp); end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
  endtask

  function automatic logic [127:0] model_out(input logic [127:0] b, input logic [127:0] k);
    return b ^ chain_m[sel] ^ k;
  endfunction

  task automatic send_word(input logic [31:0] w);
    int t;
    in_valid = 1'b1; in_data = w; t = 0;
    while (!rdy[sel] && t < 500) begin tick(); t++; end
    if (t >= 500) bad("in_ready_wait", "in_ready never rose");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [127:0] b, input logic [127:0] k, input logic gaps);
    for (int j = 0; j < 4; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      key_in = (gaps && j < 3) ? {$urandom, $urandom, $urandom, $urandom} : k;
      send_word(b[127-32*j -: 32]);
    end
  endtask

  task automatic do_block(input string tag, input logic [127:0] b, input logic [127:0] k,
                          input logic [127:0] exp_out, input int n, input logic gaps);
    int t;
    logic stable;
    logic [127:0] exp_cd;
    exp_cd = b ^ chain_m[sel];
    stub_n[sel] = n; never[sel] = 1'b0;
    issue(b, k, gaps);
    chk1({tag, "_en_rise"}, en[sel], 1'b1);
    chk1({tag, "_busy"}, busy[sel], 1'b1);
    chk({tag, "_core_data"}, cdata[sel], exp_cd);
    chk({tag, "_core_key"}, ckey[sel], k);
    t = 0; stable = 1'b1;
    while (!ovld[sel] && t < 400) begin
      if (en[sel] && (cdata[sel] !== exp_cd || ckey[sel] !== k || rdy[sel] !== 1'b0)) stable = 1'b0;
      tick(); t++;
    end
    chki({tag, "_out_latency"}, t, n + 1);
    chki({tag, "_en_cycles"}, en_len[sel], n + 1);
    chk1({tag, "_stable"}, stable, 1'b1);
    chk({tag, "_out_data"}, odata[sel], exp_out);
`ifdef AES_LOADER_CBC_EN
    if (ovld[sel]) chain_m[sel] = exp_cd ^ k;
`endif
  endtask

  task automatic accept_gap(input string tag);
    int g;
    logic ok;
    ordy[sel] = 1'b1; tick(); ordy[sel] = 1'b0;
    chk1({tag, "_ovld_drop"}, ovld[sel], 1'b0);
    chk1({tag, "_busy_gap"}, busy[sel], 1'b1);
    g = 1; ok = 1'b1;
    while (!rdy[sel] && g < 100) begin
      if (en[sel] || ovld[sel]) ok = 1'b0;
      tick(); g++;
    end
    chki({tag, "_gap"}, g, ((sel == 0) ? GAP0 : GAP1) + 1);
    chk1({tag, "_gap_quiet"}, ok, 1'b1);
    chk1({tag, "_idle"}, busy[sel], 1'b0);
  endtask

`ifdef AES_LOADER_CBC_EN
  task automatic load_iv(input logic [127:0] v);
    iv_in = v; iv_load[sel] = 1'b1; tick(); iv_load[sel] = 1'b0;
    chain_m[sel] = v;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [3];
    logic [127:0] b, k, d, c1;
    logic         ok;
    int           t;
    logic [31:0]  wq [$];

    tbl[0] = '{blk: 128'h0000007f_00000000_00000000_00000000,
               key: 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
               exp_out: 128'haa2bdb3f_bff6a5e8_caa9ba3e_bc1e2acc, n: 40};
    tbl[1] = '{blk: 128'h12345678_9abcdef0_0f0f0f0f_f0f0f0f0,
               key: {4{32'hffffffff}},
               exp_out: 128'hedcba987_6543210f_f0f0f0f0_0f0f0f0f, n: 1};
    tbl[2] = '{blk: 128'hffffffff_00000000_ffffffff_00000000,
               key: 128'h00000000_ffffffff_00000000_ffffffff,
               exp_out: {4{32'hffffffff}}, n: 5};

    in_valid = 1'b0; in_data = '0; key_in = '0; ordy = '0; eclr = '0; sel = 0; spur = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stub_n[i] = 1; never[i] = 1'b0; en_age[i] = 0; en_len[i] = 0; chain_m[i] = '0;
    end
`ifdef AES_LOADER_CBC_EN
    iv_in = '0; iv_load = '0;
`endif
    rst_n = 1'b0; repeat (3) tick(); rst_n = 1'b1; tick();

    for (int i = 0; i < 2; i++) begin
      chk1("rst_in_ready", rdy[i], 1'b1);
      chk1("rst_core_en", en[i], 1'b0);
      chk1("rst_out_valid", ovld[i], 1'b0);
      chk1("rst_busy", busy[i], 1'b0);
      chk1("rst_timeout_err", terr[i], 1'b0);
      chk("rst_core_data", cdata[i], '0);
      chk("rst_core_key", ckey[i], '0);
      chk("rst_out_data", odata[i], '0);
    end

    sel = 0;
    foreach (tbl[i]) begin
`ifdef AES_LOADER_CBC_EN
      load_iv('0);
`endif
      do_block($sformatf("vec%0d", i), tbl[i].blk, tbl[i].key, tbl[i].exp_out, tbl[i].n, 1'b0);
      accept_gap($sformatf("vec%0d", i));
    end

    // downstream backpressure
    b = 128'hdeadbeef_01234567_89abcdef_cafef00d; k = {4{32'h5a5aa5a5}};
    do_block("bp", b, k, model_out(b, k), 3, 1'b0);
    d = odata[0]; ok = 1'b1;
    repeat (20) begin
      tick();
      if (ovld[0] !== 1'b1 || odata[0] !== d || rdy[0] !== 1'b0) ok = 1'b0;
    end
    chk1("bp_hold", ok, 1'b1);
    accept_gap("bp");

    // spurious core_valid while idle and during gap
    spur = 1'b1; ok = 1'b1;
    repeat (12) begin
      tick();
      if (ovld[0] !== 1'b0 || busy[0] !== 1'b0 || odata[0] !== d) ok = 1'b0;
    end
    chk1("spur_fill", ok, 1'b1);
    b = 128'h0badf00d_11112222_33334444_55556666; k = 128'h1;
    do_block("spur", b, k, model_out(b, k), 6, 1'b0);
    accept_gap("spur");
    spur = 1'b0;

    // watchdog on the short-timeout instance
    sel = 1; never[1] = 1'b1;
    issue(b, k, 1'b0);
    t = 0;
    while (en[1] && t < 100) begin tick(); t++; end
    chki("to_en_cycles", t, 9);
    chk1("to_err_set", terr[1], 1'b1);
    ok = 1'b1;
    repeat (15) begin if (ovld[1] !== 1'b0) ok = 1'b0; tick(); end
    chk1("to_no_out", ok, 1'b1);
    chk1("to_err_sticky", terr[1], 1'b1);
    eclr[1] = 1'b1; tick(); eclr[1] = 1'b0;
    chk1("to_err_clr", terr[1], 1'b0);

    eclr[1] = 1'b1;
    issue(b, k, 1'b0);
    t = 0;
    while (en[1] && t < 100) begin tick(); t++; end
    chki("to2_en_cycles", t, 9);
    chk1("to_set_wins", terr[1], 1'b1);
    tick();
    chk1("to_clr_held", terr[1], 1'b0);
    eclr[1] = 1'b0;

    // core_valid on the timeout cycle is a capture
    b = 128'hcafebabe_00000001_80000000_76543210; k = {4{32'h0f0f0f0f}};
    do_block("coinc", b, k, model_out(b, k), 8, 1'b0);
    chk1("coinc_no_err", terr[1], 1'b0);
    accept_gap("coinc");

    // async reset during WAIT with words pending upstream
    sel = 0; never[0] = 1'b1;
    b = 128'h44444444_55555555_66666666_77777777; k = 128'h99;
    issue(b, k, 1'b0);
    repeat (4) tick();
    chk1("rst_wait_en", en[0], 1'b1);
    in_valid = 1'b1; in_data = 32'h11111111; tick(); in_data = 32'h22222222; tick();
    chk1("rst_wait_not_ready", rdy[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_async_en", en[0], 1'b0);
    chk1("rst_async_rdy", rdy[0], 1'b1);
    in_valid = 1'b0; never[0] = 1'b0;
    for (int i = 0; i < 2; i++) chain_m[i] = '0;
    tick(); rst_n = 1'b1; tick();

    // partial block discarded by reset
    key_in = k; send_word(32'haaaaaaaa); send_word(32'hbbbbbbbb);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    b = 128'h01010101_02020202_03030303_04040404;
    do_block("fresh", b, k, model_out(b, k), 2, 1'b0);
    accept_gap("fresh");

`ifdef AES_LOADER_CBC_EN
    load_iv(128'h00010203_04050607_08090a0b_0c0d0e0f);
    b = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a; k = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    c1 = b ^ 128'h00010203_04050607_08090a0b_0c0d0e0f ^ k;
    do_block("cbc1", b, k, c1, 4, 1'b0);
    accept_gap("cbc1");
    b = 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51;
    do_block("cbc2", b, k, b ^ c1 ^ k, 4, 1'b0);
    accept_gap("cbc2");
`endif

    // randomized blocks against the model
    spur = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < 4; j++) wq.push_back($urandom);
      b = '0;
      for (int j = 0; j < 4; j++) b = {b[95:0], wq.pop_front()};
      k = {$urandom, $urandom, $urandom, $urandom};
      do_block($sformatf("rnd%0d", r), b, k, model_out(b, k), $urandom_range(1, 12), 1'b1);
      d = odata[0]; ok = 1'b1;
      repeat ($urandom_range(0, 4)) begin
        tick();
        if (ovld[0] !== 1'b1 || odata[0] !== d) ok = 1'b0;
      end
      chk1($sformatf("rnd%0d_hold", r), ok, 1'b1);
      accept_gap($sformatf("rnd%0d", r));
    end
    spur = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for AES_top. Accepts a 32-bit word stream with a valid/ready handshake.
- Assembles each group of 4 words into a 128-bit block and drives the core's en/data/key inputs.
- Holds en until the core reports valid, captures the ciphertext, and presents it downstream with a valid/ready handshake.
- Adds a per-block timeout watchdog and a minimum en-low gap between blocks.

Parameters:
- TIMEOUT_CYC, 255, max cycles core_en stays high waiting for core_valid (legal range 1..65535).
- MIN_GAP, 2, cycles core_en is forced low after each block before the next issue (legal range 1..15).

Ports:
- AES_clk  in  1  clock, rising edge.
- AES_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  32  plaintext word; the first word of a block maps to bits [127:96].
- key_in  in  128  key, sampled on the cycle the 4th word is accepted.
- core_en  out  1  drives AES_en.
- core_data  out  128  drives AES_data_in.
- core_key  out  128  drives AES_key_in.
- core_valid  in  1  from AES_data_out_valid.
- core_result  in  128  from AES_data_out.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  downstream accepts.
- out_data  out  128  ciphertext.
- busy  out  1  high in any state other than FILL.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async, AES_rst_n=0): state=FILL, word count=0; all outputs 0 except in_ready=1.
- Reset mid-operation drops core_en immediately and discards any partial or in-flight block.
- States are FILL, ISSUE, WAIT, OUT and GAP.
- FILL: in_ready=1. A word is accepted when in_valid&in_ready. Word k (k=0..3) is written to bits [127-32k -: 32].
  - On accepting word 3, data and key_in are registered into core_data/core_key, and the state moves to ISSUE.
- ISSUE: core_en=1 for one cycle, timeout counter cleared, then WAIT.
  - core_data and core_key stay stable from ISSUE until the exit from WAIT.
- WAIT: core_en=1; the counter increments each cycle.
  - If core_valid=1: core_result is captured into out_data, core_en=0 next cycle, and the state moves to OUT.
  - Else if the counter reaches TIMEOUT_CYC: core_en=0, timeout_err=1, the block is discarded, and the state moves to GAP.
  - If core_valid and the timeout occur in the same cycle, core_valid wins.
- OUT: out_valid=1 and out_data is held stable until out_valid&out_ready. Then GAP.
  - While out_valid is high, out_data changes only after acceptance.
- GAP: core_en=0 for exactly MIN_GAP cycles, then FILL with count=0.
- core_valid is ignored outside WAIT. in_ready=0 outside FILL.
- Latency (no stalls): first core_en high 1 cycle after the 4th word is accepted. out_valid rises 1 cycle after core_valid.
- Throughput bound: one block per 4 + 1 + core latency + 1 + MIN_GAP cycles.
- timeout_err is cleared by err_clr=1. If err_clr and a new timeout occur in the same cycle, set wins.

Optional Feature:
- Macro AES_LOADER_CBC_EN.
- When defined:
  - Adds ports iv_in (in, 128) and iv_load (in, 1); chain register reset value is 0.
  - iv_load=1 in FILL loads iv_in into the chain register.
  - core_data = assembled block XOR chain register.
  - On capture in WAIT, the chain register is updated to core_result.
  - A timeout leaves the chain register unchanged.
- When not defined: no extra ports; core_data = assembled block.

Test Plan (core stub returns core_result = data XOR key, with core_valid pulsed N cycles after core_en rises):
- Words 0000007f,00000000,00000000,00000000 with key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc and N=40:
  - core_data=0000007f_00000000_00000000_00000000.
  - core_en high exactly 41 cycles.
  - out_data=aa2bdb3f_bff6a5e8_caa9ba3e_bc1e2acc.
- Backpressure: out_ready held 0 for 20 cycles.
  - out_valid and out_data stay stable, in_ready=0 throughout.
  - After acceptance, in_ready returns exactly MIN_GAP+1 cycles later.
- Stub never returns valid, TIMEOUT_CYC=8:
  - core_en high 9 cycles, then timeout_err=1, out_valid never asserts.
  - A later err_clr pulse clears timeout_err.
- Assert AES_rst_n=0 in WAIT after 2 of 4 words of the next block have been queued:
  - core_en=0 asynchronously.
  - After release, the next 4 words form a fresh block, with no residue from the earlier words.
- Spurious core_valid pulses in FILL/GAP:
  - No capture, out_valid stays 0.
  - core_valid and timeout in the same cycle produce a capture, not an error.
- With AES_LOADER_CBC_EN defined, iv=000102..0f, two blocks:
  - Block 1 core_data = P1 XOR iv.
  - Block 2 core_data = P2 XOR C1.
